// File: rtl/branch_pht_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_pht_ctrl_if
// Bundles the fetch-stage lookup and execute-stage resolution signals of the
// branch pattern history table controller.
//   master : pipeline side (drives lookups/updates, receives predictions)
//   slave  : branch_pht_ctrl side
// Signals:
//   ready_o        table initialised and in service
//   lookup_valid_i fetch lookup request, lookup_pc_i its PC
//   pred_valid_o   registered prediction valid, pred_taken_o its direction
//   update_valid_i branch resolved, update_pc_i/update_taken_i/update_pred_i
//   mispredict_o   registered one-cycle mispredict pulse
// ---------------------------------------------------------------------------
interface branch_pht_ctrl_if #(
  parameter int PC_WIDTH = 64
);
  logic                ready_o;
  logic                lookup_valid_i;
  logic [PC_WIDTH-1:0] lookup_pc_i;
  logic                pred_valid_o;
  logic                pred_taken_o;
  logic                update_valid_i;
  logic [PC_WIDTH-1:0] update_pc_i;
  logic                update_taken_i;
  logic                update_pred_i;
  logic                mispredict_o;

  modport master (
    input  ready_o, pred_valid_o, pred_taken_o, mispredict_o,
    output lookup_valid_i, lookup_pc_i,
    output update_valid_i, update_pc_i, update_taken_i, update_pred_i
  );

  modport slave (
    output ready_o, pred_valid_o, pred_taken_o, mispredict_o,
    input  lookup_valid_i, lookup_pc_i,
    input  update_valid_i, update_pc_i, update_taken_i, update_pred_i
  );
endinterface

// File: rtl/branch_pht_ctrl.sv
// ---------------------------------------------------------------------------
// branch_pht_ctrl
// 2-bit saturating-counter pattern history table for the branch predictor.
// After reset the table is swept to weak-not-taken (INIT), then one lookup
// and one resolution update are accepted every cycle (RUN).
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset (restarts the init sweep)
//   bus  branch_pht_ctrl_if.slave: lookup/prediction, update/mispredict, ready
//   stat_lookups_o / stat_updates_o / stat_mispredicts_o
//        saturating statistics counters, present only when the macro
//        BRANCH_PHT_STATS_EN is defined
// ---------------------------------------------------------------------------
module branch_pht_ctrl #(
  parameter int PHT_DEPTH       = 64,
  parameter int PHT_INDEX_WIDTH = 6,
  parameter int PC_WIDTH        = 64
`ifdef BRANCH_PHT_STATS_EN
  , parameter int STAT_WIDTH    = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_pht_ctrl_if.slave       bus
`ifdef BRANCH_PHT_STATS_EN
  , output logic [STAT_WIDTH-1:0] stat_lookups_o
  , output logic [STAT_WIDTH-1:0] stat_updates_o
  , output logic [STAT_WIDTH-1:0] stat_mispredicts_o
`endif
);

  // Instructions are 4 bytes; the two lowest PC bits never index the table.
  localparam int INST_BYTE_WIDTH = 4;
  localparam int IDX_LSB         = INST_BYTE_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_STRONG_TAKEN     = 2'b00,
    ST_WEAK_TAKEN       = 2'b01,
    ST_STRONG_NOT_TAKEN = 2'b10,
    ST_WEAK_NOT_TAKEN   = 2'b11
  } bpredictor_state_t;

  typedef enum logic {INIT, RUN} fsm_state_t;

  function automatic bpredictor_state_t counter_next(input bpredictor_state_t cur,
                                                     input logic taken);
    bpredictor_state_t res;
    res = cur;
    unique case (cur)
      ST_STRONG_NOT_TAKEN: res = taken ? ST_WEAK_NOT_TAKEN : ST_STRONG_NOT_TAKEN;
      ST_WEAK_NOT_TAKEN:   res = taken ? ST_WEAK_TAKEN     : ST_STRONG_NOT_TAKEN;
      ST_WEAK_TAKEN:       res = taken ? ST_STRONG_TAKEN   : ST_WEAK_NOT_TAKEN;
      ST_STRONG_TAKEN:     res = taken ? ST_STRONG_TAKEN   : ST_WEAK_TAKEN;
    endcase
    return res;
  endfunction

  fsm_state_t                 state_reg, state_next;
  logic [PHT_INDEX_WIDTH-1:0] sweep_idx_reg, sweep_idx_next;

  bpredictor_state_t          pht_mem [PHT_DEPTH];
  logic                       tbl_we;
  logic [PHT_INDEX_WIDTH-1:0] tbl_waddr;
  bpredictor_state_t          tbl_wdata;

  logic [PC_WIDTH-1:0]        lookup_pc, update_pc;
  logic [PHT_INDEX_WIDTH-1:0] lookup_idx, update_idx;
  bpredictor_state_t          update_cur, update_new, lookup_entry;
  logic                       lookup_accept, update_accept, update_mispredict;

  logic pred_valid_reg, pred_taken_reg, mispredict_reg;

  assign lookup_pc  = bus.lookup_pc_i;
  assign update_pc  = bus.update_pc_i;
  assign lookup_idx = lookup_pc[IDX_LSB +: PHT_INDEX_WIDTH];
  assign update_idx = update_pc[IDX_LSB +: PHT_INDEX_WIDTH];

  // Untagged table: PC bits outside the index field are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:IDX_LSB+PHT_INDEX_WIDTH], lookup_pc[IDX_LSB-1:0],
                            update_pc[PC_WIDTH-1:IDX_LSB+PHT_INDEX_WIDTH], update_pc[IDX_LSB-1:0]};

  // Read-modify-write of the resolved entry within the update cycle.
  assign update_cur        = pht_mem[update_idx];
  assign update_new        = counter_next(update_cur, bus.update_taken_i);
  assign update_mispredict = bus.update_taken_i ^ bus.update_pred_i;

  // Write-first bypass: a same-index update in this cycle wins over the array.
  assign lookup_entry = (update_accept && (update_idx == lookup_idx)) ? update_new
                                                                      : pht_mem[lookup_idx];

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    tbl_we         = 1'b0;
    tbl_waddr      = update_idx;
    tbl_wdata      = update_new;
    lookup_accept  = 1'b0;
    update_accept  = 1'b0;
    unique case (state_reg)
      INIT: begin
        tbl_we         = 1'b1;
        tbl_waddr      = sweep_idx_reg;
        tbl_wdata      = ST_WEAK_NOT_TAKEN;
        sweep_idx_next = sweep_idx_reg + 1'b1;
        if (sweep_idx_reg == PHT_INDEX_WIDTH'(PHT_DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        lookup_accept = bus.lookup_valid_i;
        update_accept = bus.update_valid_i;
        tbl_we        = bus.update_valid_i;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= INIT;
      sweep_idx_reg  <= '0;
      pred_valid_reg <= 1'b0;
      pred_taken_reg <= 1'b0;
      mispredict_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sweep_idx_reg  <= sweep_idx_next;
      pred_valid_reg <= lookup_accept;
      pred_taken_reg <= lookup_accept & ~lookup_entry[1];
      mispredict_reg <= update_accept & update_mispredict;
    end
  end

  // Table storage carries no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      pht_mem[tbl_waddr] <= tbl_wdata;
    end
  end

  assign bus.ready_o      = (state_reg == RUN);
  assign bus.pred_valid_o = pred_valid_reg;
  assign bus.pred_taken_o = pred_taken_reg;
  assign bus.mispredict_o = mispredict_reg;

`ifdef BRANCH_PHT_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {update_accept & update_mispredict, update_accept, lookup_accept};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [STAT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != {STAT_WIDTH{1'b1}})) begin
        cnt_reg <= cnt_reg + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_lookups_o     = g_stat[0].cnt_reg;
  assign stat_updates_o     = g_stat[1].cnt_reg;
  assign stat_mispredicts_o = g_stat[2].cnt_reg;
`endif

endmodule
